// File: rtl/mem_nic_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mau_pkg
// Description : Shared types and address-field constants for the stage-3
//               memory/NIC access unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mau_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mau_state_e;

  localparam logic [1:0] NIC_REGION_TAG = 2'b11;
  localparam int         NIC_REG_WIDTH  = 2;
  localparam int         CH_LSB         = 2;
  localparam int         CH_WIDTH       = 4;
  localparam int         PPP_WIDTH      = 3;

endpackage
`default_nettype wire

// File: rtl/mem_nic_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_nic_access_unit_if
// Description : Pipeline, DMEM, NIC and writeback signals of the stage-3
//               access unit. The unit attaches through the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_nic_access_unit_if
  import mau_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NIC_CHANNELS   = 4
);
  logic                               ex_valid;
  logic                               ex_load;
  logic                               ex_store;
  logic                               ex_wr_en;
  logic [REG_ADDR_WIDTH-1:0]          ex_rd;
  logic [PPP_WIDTH-1:0]               ex_ppp;
  logic [ADDR_WIDTH-1:0]              ex_addr;
  logic [DATA_WIDTH-1:0]              ex_wdata;
  logic [DATA_WIDTH-1:0]              alu_result;

  logic                               dmem_en;
  logic                               dmem_we;
  logic [ADDR_WIDTH-1:0]              dmem_addr;
  logic [DATA_WIDTH-1:0]              dmem_wdata;
  logic [DATA_WIDTH-1:0]              dmem_rdata;

  logic [NIC_CHANNELS-1:0]            nic_req;
  logic                               nic_we;
  logic [NIC_REG_WIDTH-1:0]           nic_reg;
  logic [DATA_WIDTH-1:0]              nic_wdata;
  logic [NIC_CHANNELS*DATA_WIDTH-1:0] nic_rdata;
  logic [NIC_CHANNELS-1:0]            nic_ack;

  logic                               stall;
  logic [DATA_WIDTH-1:0]              fwd_data;
  logic                               wb_en;
  logic [REG_ADDR_WIDTH-1:0]          wb_rd;
  logic [DATA_WIDTH-1:0]              wb_data;
  logic [PPP_WIDTH-1:0]               wb_ppp;
  logic                               err;

  modport master (
    output ex_valid, ex_load, ex_store, ex_wr_en, ex_rd, ex_ppp, ex_addr,
           ex_wdata, alu_result, dmem_rdata, nic_rdata, nic_ack,
    input  dmem_en, dmem_we, dmem_addr, dmem_wdata, nic_req, nic_we,
           nic_reg, nic_wdata, stall, fwd_data, wb_en, wb_rd, wb_data,
           wb_ppp, err
  );

  modport slave (
    input  ex_valid, ex_load, ex_store, ex_wr_en, ex_rd, ex_ppp, ex_addr,
           ex_wdata, alu_result, dmem_rdata, nic_rdata, nic_ack,
    output dmem_en, dmem_we, dmem_addr, dmem_wdata, nic_req, nic_we,
           nic_reg, nic_wdata, stall, fwd_data, wb_en, wb_rd, wb_data,
           wb_ppp, err
  );

endinterface
`default_nettype wire

// File: rtl/mem_nic_access_unit_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : mau_addr_decode
// Description : Splits a load/store address into region, NIC channel and
//               NIC register fields, and flags channels that do not exist.
// Revision    : 1.0 - initial release
// ============================================================================
module mau_addr_decode
  import mau_pkg::*;
#(
  parameter int NIC_CHANNELS = 4
) (
  input  logic [1:0]                   addr_tag,
  input  logic [CH_LSB+CH_WIDTH-1:0]   addr_low,
  output logic                         is_nic,
  output logic [CH_WIDTH-1:0]          channel,
  output logic [NIC_REG_WIDTH-1:0]     nic_reg,
  output logic                         bad_channel
);

  always_comb begin
    is_nic      = (addr_tag == NIC_REGION_TAG);
    channel     = addr_low[CH_LSB +: CH_WIDTH];
    nic_reg     = addr_low[NIC_REG_WIDTH-1:0];
    // One extra bit so NIC_CHANNELS=16 compares without wrapping
    bad_channel = is_nic & ({1'b0, channel} >= (CH_WIDTH+1)'(NIC_CHANNELS));
  end

endmodule
`default_nettype wire

// File: rtl/mem_nic_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_nic_access_unit
// Description : Stage-3 load/store steering to DMEM or NIC channels, NIC
//               wait stall, result mux, forwarding and writeback register.
//               Optional NIC ack timeout enabled by MAU_NIC_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_nic_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NIC_CHANNELS   = 4,
  parameter int NIC_TIMEOUT    = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_nic_access_unit_if.slave bus
);

  logic                      is_nic;
  logic                      bad_channel;
  logic [CH_WIDTH-1:0]       channel;
  logic [NIC_REG_WIDTH-1:0]  nic_reg;

  logic                      mem_op;
  logic                      is_load;
  logic                      nic_op;
  logic                      ack_sel;
  logic [DATA_WIDTH-1:0]     rdata_sel;
  logic [NIC_CHANNELS-1:0]   ch_onehot;
  logic                      timeout;
  logic                      error_case;
  logic [DATA_WIDTH-1:0]     result;
  logic                      stall;
  logic [NIC_CHANNELS-1:0]   nic_req;

  mau_state_e                state_q, state_d;
  logic                      wb_en_q, wb_en_d;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic [PPP_WIDTH-1:0]      wb_ppp_q, wb_ppp_d;
  logic                      err_q, err_d;

  mau_addr_decode #(
    .NIC_CHANNELS (NIC_CHANNELS)
  ) u_addr_decode (
    .addr_tag    (bus.ex_addr[ADDR_WIDTH-1 -: 2]),
    .addr_low    (bus.ex_addr[CH_LSB+CH_WIDTH-1:0]),
    .is_nic      (is_nic),
    .channel     (channel),
    .nic_reg     (nic_reg),
    .bad_channel (bad_channel)
  );

  // Reset gates every request so nothing leaves the block in the reset cycle
  always_comb begin
    mem_op  = bus.ex_valid & (bus.ex_load | bus.ex_store) & ~rst;
    is_load = bus.ex_load & ~bus.ex_store;
    nic_op  = mem_op & is_nic & ~bad_channel;
  end

  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    ch_onehot = '0;
    for (int c = 0; c < NIC_CHANNELS; c++) begin
      if (channel == CH_WIDTH'(c)) begin
        ack_sel      = bus.nic_ack[c];
        rdata_sel    = bus.nic_rdata[c*DATA_WIDTH +: DATA_WIDTH];
        ch_onehot[c] = 1'b1;
      end
    end
  end

`ifdef MAU_NIC_TIMEOUT_EN
  localparam int CNT_W = $clog2(NIC_TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign timeout = (state_q == WAIT) & nic_op & ~ack_sel &
                   (wait_cnt_q == CNT_W'(NIC_TIMEOUT));

  // Counter is zero in IDLE, so entering WAIT naturally loads 1
  always_comb begin
    wait_cnt_d = (state_d == WAIT) ? wait_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (nic_op & ~ack_sel) state_d = WAIT;
      WAIT:    if (~nic_op | ack_sel | timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall   = nic_op & ~ack_sel & ~timeout;
    nic_req = (nic_op & ~timeout) ? ch_onehot : '0;
  end

  always_comb begin
    error_case = (mem_op & bad_channel) | timeout;
    result     = is_load ? (is_nic ? rdata_sel : bus.dmem_rdata) : bus.alu_result;
  end

  // A stalled edge inserts a bubble but keeps the previous payload
  always_comb begin
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_ppp_d  = wb_ppp_q;
    if (!stall) begin
      wb_en_d   = bus.ex_valid & bus.ex_wr_en & ~bus.ex_store & ~error_case;
      wb_rd_d   = bus.ex_rd;
      wb_data_d = result;
      wb_ppp_d  = bus.ex_ppp;
    end
    err_d = err_q | error_case;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_ppp_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      wb_ppp_q  <= wb_ppp_d;
      err_q     <= err_d;
    end
  end

  assign bus.dmem_en    = mem_op & ~is_nic;
  assign bus.dmem_we    = bus.ex_store;
  assign bus.dmem_addr  = bus.ex_addr;
  assign bus.dmem_wdata = bus.ex_wdata;
  assign bus.nic_req    = nic_req;
  assign bus.nic_we     = bus.ex_store;
  assign bus.nic_reg    = nic_reg;
  assign bus.nic_wdata  = bus.ex_wdata;
  assign bus.stall      = stall;
  assign bus.fwd_data   = result;
  assign bus.wb_en      = wb_en_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_ppp     = wb_ppp_q;
  assign bus.err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_nic_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_nic_access_unit
// Description : Directed bench for mem_nic_access_unit with a writeback
//               scoreboard; timeout cases run when MAU_NIC_TIMEOUT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_nic_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic [2:0]  ppp;
  } wb_t;

  wb_t sb[$];

  always #5 clk = ~clk;

  mem_nic_access_unit_if #(
    .DATA_WIDTH(64), .ADDR_WIDTH(16), .REG_ADDR_WIDTH(5), .NIC_CHANNELS(4)
  ) bus ();

  mem_nic_access_unit #(
    .DATA_WIDTH(64), .ADDR_WIDTH(16), .REG_ADDR_WIDTH(5), .NIC_CHANNELS(4),
    .NIC_TIMEOUT(15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_valid   = 1'b0;
    bus.ex_load    = 1'b0;
    bus.ex_store   = 1'b0;
    bus.ex_wr_en   = 1'b0;
    bus.ex_rd      = '0;
    bus.ex_ppp     = '0;
    bus.ex_addr    = '0;
    bus.ex_wdata   = '0;
    bus.alu_result = '0;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic we,
                        input logic [4:0] rd, input logic [15:0] addr,
                        input logic [63:0] alu);
    bus.ex_valid   = 1'b1;
    bus.ex_load    = ld;
    bus.ex_store   = st;
    bus.ex_wr_en   = we;
    bus.ex_rd      = rd;
    bus.ex_ppp     = rd[2:0];
    bus.ex_addr    = addr;
    bus.ex_wdata   = alu ^ 64'hFFFF;
    bus.alu_result = alu;
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [63:0] data);
    wb_t e;
    e.rd   = rd;
    e.data = data;
    e.ppp  = rd[2:0];
    sb.push_back(e);
  endtask

  // Monitor: every writeback the DUT presents must match the next expected entry
  always @(negedge clk) begin
    if (bus.wb_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected actual rd=%0d data=0x%0h expected no writeback",
                 bus.wb_rd, bus.wb_data);
      end else begin
        wb_t e;
        e = sb.pop_front();
        check("wb_rd", 64'(bus.wb_rd), 64'(e.rd));
        check("wb_data", bus.wb_data, e.data);
        check("wb_ppp", 64'(bus.wb_ppp), 64'(e.ppp));
      end
    end
  end

  initial begin
    int n;
    idle();
    bus.dmem_rdata = '0;
    bus.nic_rdata  = '0;
    bus.nic_ack    = '0;
    tick();

    // Requests are gated during reset
    set_op(1'b1, 1'b0, 1'b1, 5'd7, 16'hC008, 64'h0);
    #1;
    check("rst_nic_req", 64'(bus.nic_req), 64'h0);
    check("rst_stall", 64'(bus.stall), 64'h0);
    set_op(1'b1, 1'b0, 1'b1, 5'd2, 16'h0010, 64'h0);
    #1;
    check("rst_dmem_en", 64'(bus.dmem_en), 64'h0);
    tick();
    check("rst_wb_en", 64'(bus.wb_en), 64'h0);
    check("rst_wb_rd", 64'(bus.wb_rd), 64'h0);
    check("rst_wb_data", bus.wb_data, 64'h0);
    check("rst_wb_ppp", 64'(bus.wb_ppp), 64'h0);
    check("rst_err", 64'(bus.err), 64'h0);
    rst = 1'b0;

    // ALU result writeback
    set_op(1'b0, 1'b0, 1'b1, 5'd3, 16'h0000, 64'h55);
    expect_wb(5'd3, 64'h55);
    #1;
    check("alu_stall", 64'(bus.stall), 64'h0);
    check("alu_fwd", bus.fwd_data, 64'h55);
    tick();

    // DMEM load
    set_op(1'b1, 1'b0, 1'b1, 5'd5, 16'h0010, 64'h11);
    bus.dmem_rdata = 64'hDEAD;
    expect_wb(5'd5, 64'hDEAD);
    #1;
    check("dld_dmem_en", 64'(bus.dmem_en), 64'h1);
    check("dld_dmem_we", 64'(bus.dmem_we), 64'h0);
    check("dld_dmem_addr", 64'(bus.dmem_addr), 64'h0010);
    check("dld_stall", 64'(bus.stall), 64'h0);
    check("dld_fwd", bus.fwd_data, 64'hDEAD);
    tick();

    // DMEM store: no writeback despite wr_en
    set_op(1'b0, 1'b1, 1'b1, 5'd6, 16'h0020, 64'h1234);
    #1;
    check("dst_dmem_we", 64'(bus.dmem_we), 64'h1);
    check("dst_dmem_wdata", bus.dmem_wdata, 64'hEDCB);
    check("dst_nic_req", 64'(bus.nic_req), 64'h0);
    tick();

    // NIC load ch2, ack on the fourth cycle
    set_op(1'b1, 1'b0, 1'b1, 5'd7, 16'hC008, 64'h99);
    bus.nic_rdata[2*64 +: 64] = 64'hBEEF;
    expect_wb(5'd7, 64'hBEEF);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("nld_wait_req", 64'(bus.nic_req), 64'h4);
      check("nld_wait_stall", 64'(bus.stall), 64'h1);
      check("nld_wait_wb_en", 64'(bus.wb_en), 64'h0);
      check("nld_dmem_en", 64'(bus.dmem_en), 64'h0);
      tick();
    end
    bus.nic_ack = 4'b0100;
    #1;
    check("nld_ack_req", 64'(bus.nic_req), 64'h4);
    check("nld_ack_stall", 64'(bus.stall), 64'h0);
    check("nld_ack_fwd", bus.fwd_data, 64'hBEEF);
    tick();

    // NIC store (load bit also set) ch1 with same-cycle ack
    set_op(1'b1, 1'b1, 1'b1, 5'd8, 16'hC004, 64'h0);
    bus.nic_ack = 4'b0010;
    #1;
    check("nst_nic_we", 64'(bus.nic_we), 64'h1);
    check("nst_nic_req", 64'(bus.nic_req), 64'h2);
    check("nst_stall", 64'(bus.stall), 64'h0);
    check("nst_nic_wdata", bus.nic_wdata, 64'hFFFF);
    tick();

    // NIC load ch3 reg1 with same-cycle ack
    set_op(1'b1, 1'b0, 1'b1, 5'd9, 16'hC00D, 64'h0);
    bus.nic_rdata[3*64 +: 64] = 64'hCAFE;
    bus.nic_ack = 4'b1000;
    expect_wb(5'd9, 64'hCAFE);
    #1;
    check("nreg_nic_reg", 64'(bus.nic_reg), 64'h1);
    check("nreg_nic_req", 64'(bus.nic_req), 64'h8);
    check("nreg_stall", 64'(bus.stall), 64'h0);
    tick();
    bus.nic_ack = '0;

    // Nonexistent channel 4
    set_op(1'b1, 1'b0, 1'b1, 5'd10, 16'hC010, 64'h0);
    #1;
    check("bad_nic_req", 64'(bus.nic_req), 64'h0);
    check("bad_stall", 64'(bus.stall), 64'h0);
    check("bad_dmem_en", 64'(bus.dmem_en), 64'h0);
    tick();
    check("bad_err", 64'(bus.err), 64'h1);

    // err stays sticky across normal traffic
    set_op(1'b0, 1'b0, 1'b1, 5'd11, 16'h0000, 64'h77);
    expect_wb(5'd11, 64'h77);
    tick();
    check("err_sticky", 64'(bus.err), 64'h1);

    // Reset while waiting on a NIC ack
    set_op(1'b1, 1'b0, 1'b1, 5'd12, 16'hC000, 64'h0);
    #1;
    check("rw_stall0", 64'(bus.stall), 64'h1);
    tick();
    #1;
    check("rw_stall1", 64'(bus.stall), 64'h1);
    rst = 1'b1;
    #1;
    check("rw_nic_req", 64'(bus.nic_req), 64'h0);
    check("rw_stall_rst", 64'(bus.stall), 64'h0);
    tick();
    check("rw_err_clr", 64'(bus.err), 64'h0);
    check("rw_wb_en", 64'(bus.wb_en), 64'h0);
    rst = 1'b0;
    idle();
    tick();

`ifdef MAU_NIC_TIMEOUT_EN
    // Unacknowledged NIC load aborts after the timeout
    set_op(1'b1, 1'b0, 1'b1, 5'd13, 16'hC004, 64'h0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!bus.stall) break;
      n++;
      tick();
    end
    check("to_stall_cycles", 64'(n), 64'd15);
    check("to_nic_req", 64'(bus.nic_req), 64'h0);
    tick();
    idle();
    check("to_err", 64'(bus.err), 64'h1);
    bus.nic_ack = 4'b0010;
    #1;
    check("to_late_ack_stall", 64'(bus.stall), 64'h0);
    tick();
    bus.nic_ack = '0;
`endif

    idle();
    n = 0;
    repeat (3) tick();
    check("sb_empty", 64'(sb.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_nic_access_unit.md
Name: mem_nic_access_unit

Overview:
- Stage-3 (EXE/MEM) memory access unit for the 4-stage pipeline.
- Steers loads and stores to DMEM or to one of N NIC channels by address decode.
- Stalls the pipeline while a NIC access waits for its acknowledge.
- Owns the stage-3/WB register: result mux, writeback register, and stage-3 forwarding data in one block.

Parameters:
- DATA_WIDTH, 64, data path width
- ADDR_WIDTH, 16, load/store address width
- REG_ADDR_WIDTH, 5, register-file address width
- NIC_CHANNELS, 4, number of NIC channels (1..16)
- NIC_TIMEOUT, 15, max wait cycles for nic_ack (only with the optional feature)

Ports:
- clk in 1: clock
- rst in 1: synchronous active-high reset
- ex_valid in 1: stage-3 instruction valid
- ex_load in 1: instruction is a load
- ex_store in 1: instruction is a store
- ex_wr_en in 1: instruction writes the register file
- ex_rd in REG_ADDR_WIDTH: destination register
- ex_ppp in 3: byte-lane write mask code passed to the register file
- ex_addr in ADDR_WIDTH: load/store address
- ex_wdata in DATA_WIDTH: store data
- alu_result in DATA_WIDTH: ALU output
- dmem_en out 1; dmem_we out 1; dmem_addr out ADDR_WIDTH; dmem_wdata out DATA_WIDTH
- dmem_rdata in DATA_WIDTH: asynchronous DMEM read data
- nic_req out NIC_CHANNELS: one-hot request
- nic_we out 1; nic_reg out 2; nic_wdata out DATA_WIDTH
- nic_rdata in NIC_CHANNELS*DATA_WIDTH: channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
- nic_ack in NIC_CHANNELS
- stall out 1: freezes stages 1-3
- fwd_data out DATA_WIDTH: stage-3 forwarding value for the HDU muxes
- wb_en out 1; wb_rd out REG_ADDR_WIDTH; wb_data out DATA_WIDTH; wb_ppp out 3
- err out 1: sticky error flag

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: wb_en=0, wb_rd=0, wb_data=0, wb_ppp=0, err=0, FSM=IDLE, wait counter=0. nic_req and dmem_en are gated low while rst=1.
- Decode:
  - mem_op = ex_valid & (ex_load | ex_store).
  - NIC region when ex_addr[ADDR_WIDTH-1:ADDR_WIDTH-2]==2'b11; otherwise DMEM.
  - Channel = ex_addr[5:2]; nic_reg = ex_addr[1:0].
  - Channel >= NIC_CHANNELS: no request, err<=1, access completes as a bubble (wb_en=0).
- Load and store both set: treated as a store; no writeback.
- DMEM access, zero stall:
  - dmem_en=mem_op & DMEM region; dmem_we=store; dmem_addr=ex_addr; dmem_wdata=ex_wdata.
  - Load data is registered into wb_data at the next edge.
- NIC access:
  - nic_req[ch] is asserted combinationally from IDLE or WAIT while the NIC op is present.
  - stall = nic_op & ~nic_ack[ch], a combinational ack-to-stall path.
  - Upstream holds all ex_* inputs stable while stall=1.
- FSM:
  - IDLE: NIC op and no ack -> WAIT, counter<=1. NIC op with ack -> stay IDLE; the access completes this edge.
  - WAIT: ack -> IDLE, counter<=0, access completes. Otherwise counter increments.
- Writeback register, updated every non-stalled edge:
  - wb_en = ex_valid & ex_wr_en & ~ex_store & ~error_case.
  - wb_rd = ex_rd; wb_ppp = ex_ppp.
  - wb_data = load ? (NIC ? selected nic_rdata : dmem_rdata) : alu_result.
  - While stall=1: wb_en<=0 (bubble); other wb fields hold.
- fwd_data: the same combinational mux as wb_data input. Latency to writeback is 1 cycle after completion.
- Reset during WAIT: FSM returns to IDLE, request is dropped in the reset cycle, no writeback.
- err is cleared only by rst.

Optional Feature:
- Macro: MAU_NIC_TIMEOUT_EN.
- Defined: when the WAIT counter reaches NIC_TIMEOUT with no ack, the access aborts.
  - stall drops that cycle; nic_req drops; wb_en=0; err<=1; FSM -> IDLE.
  - A late ack arriving in IDLE is ignored.
- Undefined: WAIT is unbounded; counter logic is absent; err is set only by a bad channel index.

Decomposition:
- Package mau_pkg holds:
  - FSM state enum {IDLE, WAIT}
  - NIC region tag 2'b11 and channel field position
  - ppp width (3)
- One combinational sub-module is natural: mau_addr_decode. It maps ex_addr to is_nic, channel index, nic_reg and bad_channel.

Test Plan:
- Reset, then ALU op rd=3, alu_result=0x55 -> next cycle wb_en=1, wb_rd=3, wb_data=0x55; stall never asserted.
- DMEM load addr 0x0010, dmem_rdata=0xDEAD -> dmem_en=1, dmem_we=0, no stall; next cycle wb_data=0xDEAD.
- NIC load addr 0xC008 (ch2, reg0), ack after 3 cycles with data 0xBEEF -> nic_req=4'b0100 for 4 cycles, stall=1 for 3 cycles, wb_en=0 during the stall, then wb_data=0xBEEF for one cycle.
- NIC store addr 0xC004 with same-cycle ack -> nic_we=1, stall=0, wb_en=0.
- Load at 0xC010 (channel 4, NIC_CHANNELS=4) -> no nic_req, err=1, wb_en=0. Then rst -> err=0.
- With MAU_NIC_TIMEOUT_EN, NIC load with no ack -> abort after 15 wait cycles, err=1, FSM IDLE. rst asserted mid-WAIT -> nic_req=0 and no writeback.
